note_lane_scheduler: RTL and testbench
======================================

# note_lane_scheduler

Sequences per-frame redraw of the 10-slot note lane onto the VGA adapter pixel port. On each frame tick it snapshots the red/yellow note sequences and walks every slot's 4x4 square pixel by pixel, emitting one x/y/colour/plot per cycle. It then optionally draws the green hit indicator requested by the judge logic. It sits between the note shifters and hit judge on one side and the VGA adapter's plot inputs on the other.

## Interface
- X_START, 10, x of slot 0's left column
- X_STEP, 10, x spacing between slots
- Y_ROW, 112, top row of lane squares
- HIT_Y, 106, top row of hit indicator square (x = X_START)
- clk  in  1  system clock
- reset  in  1  reset; one clock, synchronous, active-high
- frame_tick  in  1  one-cycle pulse: start a frame redraw
- red_sequence  in  10  bit i = red note in slot i
- yellow_sequence  in  10  bit i = yellow note in slot i
- hit_flash  in  1  one-cycle pulse: request hit indicator draw
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour {R,G,B}
- plot  out  1  pixel write enable
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse: frame complete
- overrun  out  1  sticky: frame_tick arrived while busy

## Operation
- States: IDLE, DRAW, HIT, DONE.
- IDLE: frame_tick=1 -> latch red/yellow into snapshot regs, slot=0, pix=0, go DRAW.
- DRAW: plot=1 every cycle. x = X_START + slot*X_STEP + pix[1:0]; y = Y_ROW + pix[3:2]. pix increments 0..15; at 15, pix wraps to 0 and slot increments. After slot 9 pix 15: hit_pending ? HIT : DONE.
- Colour from snapshot bit of current slot: red only 100, yellow only 110, both 001 (blue), neither 000 (black erases stale note).
- HIT: clears hit_pending on entry. 16 cycles, plot=1, colour 010, x = X_START + pix[1:0], y = HIT_Y + pix[3:2]. Then DONE.
- DONE: done=1, plot=0, one cycle, then IDLE.
- hit_pending: set by hit_flash in any state, including the cycle HIT would clear it. Set wins, so a flash arriving while HIT is being entered is kept for the next frame.
- frame_tick while busy: ignored, overrun set (sticky until reset). Snapshot is not updated mid-frame.
- Simultaneous frame_tick and hit_flash in IDLE: both captured; that frame includes HIT.
- Width rules: x arithmetic in 8 bits, y in 7 bits, no saturation. Parameters must keep x ≤ 159 and y ≤ 119; the defaults give max x 103 and max y 115.
- Outputs in IDLE/DONE: x=0, y=0, colour=000, plot=0.

## Timing
- Reset values: state IDLE, slot 0, pix 0, snapshot 0, hit_pending 0, overrun 0. Outputs: x 0, y 0, colour 000, plot 0, busy 0, done 0.
- Outputs decode from registered state/counters; no combinational path from inputs to outputs.
- frame_tick sampled at edge E0 -> plot=1 with slot 0 pixel 0 in the cycle after E0.
- DRAW lasts exactly 160 cycles, HIT 16, DONE 1.
- done is high in cycle 161 after E0 without HIT, or 177 with HIT.
- busy=1 from the cycle after E0 through DONE inclusive.
- frame_tick in the IDLE cycle immediately after DONE is accepted, so back-to-back frames are possible.
- Reset mid-frame: next cycle is IDLE with all reset values; no done pulse.

## Configuration
- HIT_FLASH_EN defined: HIT state, hit_pending and HIT_Y are active as above.
- HIT_FLASH_EN undefined: HIT state and hit_pending are compiled out. hit_flash is present but ignored. DRAW always goes to DONE, so frame length is fixed at 161 cycles.

## Test plan
- Reset, then idle 20 cycles: all outputs at reset values.
- red=10'b0000000001, yellow=10'b1000000000, frame_tick at E0. Expect:
  - plot high for 160 cycles.
  - First pixel (10,112) colour 100; slot 0 last pixel (13,115).
  - Slot 9 pixels x=100..103, colour 110; slots 1–8 colour 000.
  - done pulses at cycle 161 (HIT_FLASH_EN undefined, or no hit_flash since reset).
- red=yellow=10'h3FF: all 160 pixels colour 001.
- hit_flash mid-DRAW (HIT_FLASH_EN defined): after 160 lane pixels, 16 pixels at x 10..13, y 106..109, colour 010; done at cycle 177. A following frame without hit_flash has no HIT.
- frame_tick again at cycle 50 of DRAW: overrun=1 and stays 1. Frame completes normally with the original snapshot despite sequences changing mid-frame.
- reset asserted at cycle 80 of DRAW: next cycle plot=0, busy=0, no done. A new frame_tick restarts at slot 0 pixel 0.

Source files
------------

// File: rtl/note_lane_scheduler_if.sv
// Pixel bus from the note lane scheduler to the VGA adapter plot inputs.
// plot is a one-cycle valid with no ready: the adapter accepts every plotted pixel.
interface note_lane_scheduler_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/note_lane_scheduler.sv
// Per-frame redraw of the 10-slot note lane onto the VGA pixel bus.
// Optional hit indicator square is enabled with `define HIT_FLASH_EN.
module note_lane_scheduler #(
  parameter logic [7:0] X_START = 8'd10,
  parameter logic [7:0] X_STEP  = 8'd10,
  parameter logic [6:0] Y_ROW   = 7'd112,
  parameter logic [6:0] HIT_Y   = 7'd106
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [9:0]                    red_sequence,
  input  logic [9:0]                    yellow_sequence,
  input  logic                          hit_flash,
  note_lane_scheduler_if.master         pix,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output logic [1:0]                    state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_HIT, S_DONE} state_t;

  state_t     state, state_n;
  logic [3:0] slot, slot_n;
  logic [3:0] pix_cnt, pix_n;
  logic [9:0] snap_red, snap_red_n;
  logic [9:0] snap_yel, snap_yel_n;
  logic       overrun_n;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic [2:0] colour_n;
  logic       plot_n;
  logic       lane_r, lane_y;
  state_t     after_lane;

`ifdef HIT_FLASH_EN
  logic hit_pending, hit_pending_n;
  assign after_lane = hit_pending ? S_HIT : S_DONE;
`else
  logic unused_hit;
  assign unused_hit = ^{hit_flash, HIT_Y};
  assign after_lane = S_DONE;
`endif

  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    slot_n     = slot;
    pix_n      = pix_cnt;
    snap_red_n = snap_red;
    snap_yel_n = snap_yel;
    overrun_n  = overrun;
    case (state)
      S_IDLE: if (frame_tick) begin
        snap_red_n = red_sequence;
        snap_yel_n = yellow_sequence;
        slot_n     = 4'd0;
        pix_n      = 4'd0;
        state_n    = S_DRAW;
      end
      S_DRAW: begin
        pix_n = pix_cnt + 4'd1;
        if (pix_cnt == 4'd15) begin
          if (slot == 4'd9) begin
            slot_n  = 4'd0;
            state_n = after_lane;
          end else begin
            slot_n = slot + 4'd1;
          end
        end
      end
`ifdef HIT_FLASH_EN
      S_HIT: begin
        pix_n = pix_cnt + 4'd1;
        if (pix_cnt == 4'd15) state_n = S_DONE;
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // A tick outside IDLE is dropped; the snapshot stays frozen for the frame.
    if (frame_tick && state != S_IDLE) overrun_n = 1'b1;
`ifdef HIT_FLASH_EN
    hit_pending_n = hit_pending;
    if (state_n == S_HIT && state != S_HIT) hit_pending_n = 1'b0;
    if (hit_flash) hit_pending_n = 1'b1;
`endif
  end

  // Outputs are decoded from the next-state values so they register in step with state.
  always_comb begin
    x_n      = 8'd0;
    y_n      = 7'd0;
    colour_n = 3'b000;
    plot_n   = 1'b0;
    lane_r   = snap_red_n[slot_n];
    lane_y   = snap_yel_n[slot_n];
    case (state_n)
      S_DRAW: begin
        plot_n = 1'b1;
        x_n    = X_START + 8'(slot_n) * X_STEP + 8'(pix_n[1:0]);
        y_n    = Y_ROW + 7'(pix_n[3:2]);
        case ({lane_r, lane_y})
          2'b10:   colour_n = 3'b100;
          2'b01:   colour_n = 3'b110;
          2'b11:   colour_n = 3'b001;
          default: colour_n = 3'b000;
        endcase
      end
`ifdef HIT_FLASH_EN
      S_HIT: begin
        plot_n   = 1'b1;
        x_n      = X_START + 8'(pix_n[1:0]);
        y_n      = HIT_Y + 7'(pix_n[3:2]);
        colour_n = 3'b010;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      slot       <= 4'd0;
      pix_cnt    <= 4'd0;
      snap_red   <= 10'd0;
      snap_yel   <= 10'd0;
      overrun    <= 1'b0;
      pix.x      <= 8'd0;
      pix.y      <= 7'd0;
      pix.colour <= 3'b000;
      pix.plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef HIT_FLASH_EN
      hit_pending <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      pix_cnt    <= pix_n;
      snap_red   <= snap_red_n;
      snap_yel   <= snap_yel_n;
      overrun    <= overrun_n;
      pix.x      <= x_n;
      pix.y      <= y_n;
      pix.colour <= colour_n;
      pix.plot   <= plot_n;
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
`ifdef HIT_FLASH_EN
      hit_pending <= hit_pending_n;
`endif
    end
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Scoreboard bench for note_lane_scheduler: driver pushes expected pixels and done cycles,
// a negedge monitor pops and compares whenever plot or done is presented.
module tb_note_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       hit_flash = 1'b0;
  logic [9:0] red_sequence = 10'd0;
  logic [9:0] yellow_sequence = 10'd0;
  logic       busy, done, overrun;
  logic [1:0] state_dbg;

  note_lane_scheduler_if pif();

  note_lane_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .red_sequence    (red_sequence),
    .yellow_sequence (yellow_sequence),
    .hit_flash       (hit_flash),
    .pix             (pif),
    .busy            (busy),
    .done            (done),
    .overrun         (overrun),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int          exp_done_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] lane_pixel(input int s, input int p,
                                             input logic [9:0] r, input logic [9:0] yl);
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] c;
    px = 8'(10 + 10 * s + (p % 4));
    py = 7'(112 + (p / 4));
    case ({r[s], yl[s]})
      2'b10:   c = 3'b100;
      2'b01:   c = 3'b110;
      2'b11:   c = 3'b001;
      default: c = 3'b000;
    endcase
    return {px, py, c};
  endfunction

  always @(negedge clk) begin
    if (pif.plot === 1'b1) begin
      if (exp_q.size() == 0) check("pixel_unexpected", {14'd0, pif.x, pif.y, pif.colour}, 32'hFFFF_FFFF);
      else check("pixel", {14'd0, pif.x, pif.y, pif.colour}, {14'd0, exp_q.pop_front()});
    end
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) check("done_unexpected", cyc, 32'hFFFF_FFFF);
      else check("done_cycle", cyc, exp_done_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_lane(input logic [9:0] r, input logic [9:0] yl, input int n_pix);
    for (int i = 0; i < n_pix; i++) exp_q.push_back(lane_pixel(i / 16, i % 16, r, yl));
  endtask

  task automatic push_hit();
    for (int p = 0; p < 16; p++)
      exp_q.push_back({8'(10 + (p % 4)), 7'(106 + (p / 4)), 3'b010});
  endtask

  // Called at a negedge in IDLE; returns in cycle 1 of the frame.
  task automatic start_frame(input logic [9:0] r, input logic [9:0] yl, output int e0);
    red_sequence    = r;
    yellow_sequence = yl;
    frame_tick      = 1'b1;
    e0              = cyc + 1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("busy_start", busy, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name, input logic exp_overrun);
    check(name, {pif.x, pif.y, pif.colour, pif.plot, busy, done, overrun, state_dbg},
          {8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, exp_overrun, 2'd0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("reset_idle", 1'b0);
    end

    // red in slot 0, yellow in slot 9, everything else erased
    push_lane(10'b0000000001, 10'b1000000000, 160);
    start_frame(10'b0000000001, 10'b1000000000, e0);
    exp_done_q.push_back(e0 + 160);
    wait_done();
    check_idle("idle_after_f1", 1'b0);

    // back-to-back: all slots hold both colours
    push_lane(10'h3FF, 10'h3FF, 160);
    start_frame(10'h3FF, 10'h3FF, e0);
    exp_done_q.push_back(e0 + 160);
    wait_done();

    // hit_flash mid-frame
    push_lane(10'b0000110011, 10'b0011000011, 160);
`ifdef HIT_FLASH_EN
    push_hit();
`endif
    start_frame(10'b0000110011, 10'b0011000011, e0);
`ifdef HIT_FLASH_EN
    exp_done_q.push_back(e0 + 176);
`else
    exp_done_q.push_back(e0 + 160);
`endif
    repeat (19) @(negedge clk);
    hit_flash = 1'b1;
    @(negedge clk);
    hit_flash = 1'b0;
    wait_done();

`ifdef HIT_FLASH_EN
    // the flash was consumed, so this frame has no indicator
    push_lane(10'b1000000001, 10'd0, 160);
    start_frame(10'b1000000001, 10'd0, e0);
    exp_done_q.push_back(e0 + 160);
    wait_done();
`endif

    // overrun: second tick at DRAW cycle 50 with changed sequences
    push_lane(10'b0101010101, 10'b0011001100, 160);
    start_frame(10'b0101010101, 10'b0011001100, e0);
    exp_done_q.push_back(e0 + 160);
    check("overrun_before", overrun, 0);
    repeat (49) @(negedge clk);
    frame_tick      = 1'b1;
    red_sequence    = 10'b1010101010;
    yellow_sequence = 10'b1100110011;
    @(negedge clk);
    frame_tick = 1'b0;
    check("overrun_set", overrun, 1);
    wait_done();
    check_idle("overrun_sticky", 1'b1);

    // reset at DRAW cycle 80: only 80 pixels, no done
    push_lane(10'b0000000011, 10'b1100000000, 80);
    start_frame(10'b0000000011, 10'b1100000000, e0);
    repeat (79) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_frame_reset", 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("after_reset_idle", 1'b0);

    // restart from slot 0 pixel 0
    push_lane(10'b0000000011, 10'b1100000000, 160);
    start_frame(10'b0000000011, 10'b1100000000, e0);
    exp_done_q.push_back(e0 + 160);
    wait_done();
    check_idle("final_idle", 1'b0);

    check("pixels_left", exp_q.size(), 0);
    check("dones_left", exp_done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
